// File: rtl/chaos_ch_capture_buf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : chaos_ch_capture_buf_pkg                                    |
// | Brief   : Shared defaults, sample record type and helpers for the     |
// |           chaotic-system per-channel capture buffer.                  |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package chaos_ch_capture_buf_pkg;

  // Width of one state variable, matching the floating-point IP word.
  localparam int CHAOS_DATA_WIDTH = 64;
  // Number of time-multiplexed chaotic systems.
  localparam int CHAOS_NUM_CH     = 6;

  // One captured sample: x, y, z stored side by side in one RAM word.
  typedef struct packed {
    logic signed [CHAOS_DATA_WIDTH-1:0] x;
    logic signed [CHAOS_DATA_WIDTH-1:0] y;
    logic signed [CHAOS_DATA_WIDTH-1:0] z;
  } xyz_sample_t;

  // Bits needed to index n channels inside the RAM address (at least one).
  function automatic int ch_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chaos_ch_capture_buf_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : chaos_ch_capture_buf_if                                   |
// | Brief     : Sample input, host pop/report and status signals of the   |
// |             per-channel capture buffer.                               |
// | Rev       : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface chaos_ch_capture_buf_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_CH     = 6,
  parameter int DEPTH      = 16,
  parameter int CH_W       = 8,
  parameter int DEC_W      = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  clr;
  logic                  in_valid;
  logic [CH_W-1:0]       in_ch;
  logic [DATA_WIDTH-1:0] in_x;
  logic [DATA_WIDTH-1:0] in_y;
  logic [DATA_WIDTH-1:0] in_z;
  logic [DEC_W-1:0]      decim;
  logic                  rd_en;
  logic [CH_W-1:0]       rd_ch;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_x;
  logic [DATA_WIDTH-1:0] rd_y;
  logic [DATA_WIDTH-1:0] rd_z;
  logic [CH_W-1:0]       rd_tag;
  logic [CNT_W-1:0]      rd_count;
  logic [NUM_CH-1:0]     ovf_flags;
  logic                  bad_ch;

  // Producer / host side.
  modport master (
    output clr, in_valid, in_ch, in_x, in_y, in_z, decim, rd_en, rd_ch,
    input  rd_valid, rd_x, rd_y, rd_z, rd_tag, rd_count, ovf_flags, bad_ch
  );

  // Capture buffer side.
  modport slave (
    input  clr, in_valid, in_ch, in_x, in_y, in_z, decim, rd_en, rd_ch,
    output rd_valid, rd_x, rd_y, rd_z, rd_tag, rd_count, ovf_flags, bad_ch
  );
endinterface
`default_nettype wire

// File: rtl/chaos_ch_capture_buf_fifo_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : chaos_ch_fifo_ctl                                            |
// | Brief  : Pointer, fill-count, decimation and overflow bookkeeping of  |
// |          one channel FIFO; the data lives in the shared RAM.          |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module chaos_ch_fifo_ctl #(
  parameter  int DEPTH = 16,
  parameter  int DEC_W = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  wire              clk,
  input  wire              rst_n,
  input  wire              clr,
  input  wire              wr_req,
  input  wire              rd_req,
  input  wire  [DEC_W-1:0] decim,
  output logic             wr_ok,
  output logic             rd_ok,
  output logic [PTR_W-1:0] wp,
  output logic [PTR_W-1:0] rp,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEC_W-1:0] dc_q, dc_d;
  logic             ovf_q, ovf_d;
  logic [DEC_W-1:0] dec_max;
  logic [DEC_W:0]   dc_inc;
  logic             keep;

  // Accept/refuse decisions and next-state bookkeeping for this channel.
  always_comb begin
    dec_max = (decim == '0) ? DEC_W'(1) : decim;
    dc_inc  = {1'b0, dc_q} + (DEC_W + 1)'(1);
    keep    = wr_req && (dc_q == '0);
    // Pop looks at the fill before this cycle's write, so an empty FIFO refuses it.
    rd_ok   = rd_req && (count_q != '0) && !clr;
    // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
    wr_ok   = keep && ((count_q != CNT_W'(DEPTH)) || rd_ok) && !clr;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    dc_d    = dc_q;
    ovf_d   = ovf_q;
    if (clr) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
      dc_d    = '0;
      ovf_d   = 1'b0;
    end else begin
      // Using >= lets a lowered decim take hold at the next wrap instead of running past it.
      if (wr_req) dc_d = (dc_inc >= {1'b0, dec_max}) ? '0 : dc_inc[DEC_W-1:0];
      if (wr_ok) wp_d = wp_q + PTR_W'(1);
      if (rd_ok) rp_d = rp_q + PTR_W'(1);
      if (wr_ok && !rd_ok)      count_d = count_q + CNT_W'(1);
      else if (rd_ok && !wr_ok) count_d = count_q - CNT_W'(1);
      if (keep && !wr_ok) ovf_d = 1'b1;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      dc_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      dc_q    <= dc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wp    = wp_q;
  assign rp    = rp_q;
  assign count = count_q;
  assign ovf   = ovf_q;

endmodule
`default_nettype wire

// File: rtl/chaos_ch_capture_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : chaos_ch_capture_buf                                         |
// | Brief  : Demultiplexes Chaotic_TOP samples into per-channel circular  |
// |          FIFOs held in one shared simple dual-port RAM; host pops.    |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module chaos_ch_capture_buf
  import chaos_ch_capture_buf_pkg::*;
#(
  parameter int DATA_WIDTH = CHAOS_DATA_WIDTH,
  parameter int NUM_CH     = CHAOS_NUM_CH,
  parameter int DEPTH      = 16,
  parameter int CH_W       = 8,
  parameter int DEC_W      = 8
) (
  input wire clk,
  input wire rst_n,
  chaos_ch_capture_buf_if.slave bus
);

  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = $clog2(DEPTH + 1);
  localparam int IDX_W     = ch_idx_width(NUM_CH);
  localparam int ADDR_W    = IDX_W + PTR_W;
  localparam int MEM_WORDS = NUM_CH * DEPTH;

  logic [NUM_CH-1:0] wr_req, rd_req, wr_ok, rd_ok, ovf;
  logic [PTR_W-1:0]  wp [NUM_CH];
  logic [PTR_W-1:0]  rp [NUM_CH];
  logic [CNT_W-1:0]  count [NUM_CH];

  logic                    in_range;
  logic                    ram_we, ram_re;
  logic [ADDR_W-1:0]       ram_waddr, ram_raddr;
  logic [3*DATA_WIDTH-1:0] ram_wdata;
  logic [3*DATA_WIDTH-1:0] mem [MEM_WORDS];
  xyz_sample_t             ram_rdata_q;
  logic [CNT_W-1:0]        rd_count_w;

  logic            rd_valid_q, rd_valid_d;
  logic [CH_W-1:0] rd_tag_q, rd_tag_d;
  logic            bad_ch_q, bad_ch_d;

  assign in_range  = (32'(bus.in_ch) < 32'(NUM_CH));
  assign ram_wdata = {bus.in_x, bus.in_y, bus.in_z};

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    assign wr_req[ch] = bus.in_valid && (bus.in_ch == CH_W'(ch));
    assign rd_req[ch] = bus.rd_en && (bus.rd_ch == CH_W'(ch));

    chaos_ch_fifo_ctl #(
      .DEPTH (DEPTH),
      .DEC_W (DEC_W)
    ) u_ctl (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (bus.clr),
      .wr_req (wr_req[ch]),
      .rd_req (rd_req[ch]),
      .decim  (bus.decim),
      .wr_ok  (wr_ok[ch]),
      .rd_ok  (rd_ok[ch]),
      .wp     (wp[ch]),
      .rp     (rp[ch]),
      .count  (count[ch]),
      .ovf    (ovf[ch])
    );
  end

  // Steer the single accepted write / pop onto the RAM ports and pick the reported fill.
  always_comb begin
    ram_we     = 1'b0;
    ram_waddr  = '0;
    ram_re     = 1'b0;
    ram_raddr  = '0;
    rd_count_w = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (wr_ok[ch]) begin
        ram_we    = 1'b1;
        ram_waddr = {IDX_W'(ch), wp[ch]};
      end
      if (rd_ok[ch]) begin
        ram_re    = 1'b1;
        ram_raddr = {IDX_W'(ch), rp[ch]};
      end
      if (bus.rd_ch == CH_W'(ch)) rd_count_w = count[ch];
    end
  end

  // Shared sample RAM; read-before-write keeps a full-FIFO write+pop returning the oldest entry.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata_q <= mem[ram_raddr];
  end

  // Read strobe, tag and sticky bad-index flag.
  always_comb begin
    rd_valid_d = |rd_ok;
    rd_tag_d   = rd_tag_q;
    bad_ch_d   = bad_ch_q;
    if (bus.clr) begin
      bad_ch_d = 1'b0;
    end else begin
      if (|rd_ok) rd_tag_d = bus.rd_ch;
      if (bus.in_valid && !in_range) bad_ch_d = 1'b1;
    end
  end

  // Output-side control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_tag_q   <= '0;
      bad_ch_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_tag_q   <= rd_tag_d;
      bad_ch_q   <= bad_ch_d;
    end
  end

  // The RAM read register is not reset, so data is forced to zero outside a valid pulse.
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_x      = rd_valid_q ? ram_rdata_q.x : '0;
  assign bus.rd_y      = rd_valid_q ? ram_rdata_q.y : '0;
  assign bus.rd_z      = rd_valid_q ? ram_rdata_q.z : '0;
  assign bus.rd_tag    = rd_tag_q;
  assign bus.rd_count  = rd_count_w;
  assign bus.ovf_flags = ovf;
  assign bus.bad_ch    = bad_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_chaos_ch_capture_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_chaos_ch_capture_buf                                      |
// | Brief  : Directed self-checking bench with a queue-per-channel model  |
// |          and a scoreboard of expected pops.                           |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module tb_chaos_ch_capture_buf;

  localparam int DW    = 64;
  localparam int NCH   = 6;
  localparam int DEPTH = 16;
  localparam int CH_W  = 8;
  localparam int DEC_W = 8;
  localparam int WW    = 3 * DW;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  chaos_ch_capture_buf_if #(
    .DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(DEPTH), .CH_W(CH_W), .DEC_W(DEC_W)
  ) bus ();

  chaos_ch_capture_buf #(
    .DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(DEPTH), .CH_W(CH_W), .DEC_W(DEC_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [WW-1:0]      mq [NCH][$];
  logic [CH_W+WW-1:0] sb [$];
  int                 dcm [NCH];
  logic [NCH-1:0]     ovf_m;
  logic               bad_m;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] mk(input logic [DW-1:0] x);
    return {x, ~x, DW'(0) - x};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      dcm[c] = 0;
    end
    sb.delete();
    ovf_m = '0;
    bad_m = 1'b0;
  endtask

  // One clock: drive, update the model, then check the pop result after the edge.
  task automatic step(input logic v, input int ch, input logic [DW-1:0] x,
                      input logic re, input int rch, input logic cl);
    logic               pop_ok;
    logic               keep;
    int                 dmax;
    logic [CH_W+WW-1:0] e;
    bus.in_valid = v;
    bus.in_ch    = CH_W'(ch);
    bus.in_x     = x;
    bus.in_y     = ~x;
    bus.in_z     = DW'(0) - x;
    bus.rd_en    = re;
    bus.rd_ch    = CH_W'(rch);
    bus.clr      = cl;
    pop_ok = 1'b0;
    if (cl) begin
      model_reset();
    end else begin
      if (re && rch < NCH) begin
        if (mq[rch].size() > 0) begin
          pop_ok = 1'b1;
          sb.push_back({CH_W'(rch), mq[rch].pop_front()});
        end
      end
      if (v) begin
        if (ch >= NCH) begin
          bad_m = 1'b1;
        end else begin
          dmax    = (bus.decim == 0) ? 1 : int'(bus.decim);
          keep    = (dcm[ch] == 0);
          dcm[ch] = (dcm[ch] + 1) % dmax;
          if (keep) begin
            if (mq[ch].size() < DEPTH) mq[ch].push_back(mk(x));
            else ovf_m[ch] = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    chk("rd_valid", 256'(bus.rd_valid), 256'(pop_ok));
    if (pop_ok) begin
      e = sb.pop_front();
      chk("rd_data", 256'({bus.rd_x, bus.rd_y, bus.rd_z}), 256'(e[WW-1:0]));
      chk("rd_tag", 256'(bus.rd_tag), 256'(e[CH_W+WW-1:WW]));
    end
    bus.in_valid = 1'b0;
    bus.rd_en    = 1'b0;
    bus.clr      = 1'b0;
  endtask

  task automatic wr(input int ch, input logic [DW-1:0] x);
    step(1'b1, ch, x, 1'b0, 0, 1'b0);
  endtask

  task automatic pop(input int ch);
    step(1'b0, 0, '0, 1'b1, ch, 1'b0);
  endtask

  task automatic clear();
    step(1'b0, 0, '0, 1'b0, 0, 1'b1);
  endtask

  // Compare every channel's fill and the sticky flags against the model.
  task automatic check_state(input string tag);
    for (int c = 0; c < NCH; c++) begin
      bus.rd_ch = CH_W'(c);
      #1;
      chk({tag, "_count"}, 256'(bus.rd_count), 256'(mq[c].size()));
    end
    chk({tag, "_ovf"}, 256'(bus.ovf_flags), 256'(ovf_m));
    chk({tag, "_bad"}, 256'(bus.bad_ch), 256'(bad_m));
  endtask

  initial begin
    bus.clr = 1'b0; bus.in_valid = 1'b0; bus.in_ch = '0;
    bus.in_x = '0; bus.in_y = '0; bus.in_z = '0;
    bus.decim = DEC_W'(1); bus.rd_en = 1'b0; bus.rd_ch = '0;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_rd_valid", 256'(bus.rd_valid), 256'(0));
    chk("rst_rd_x", 256'(bus.rd_x), 256'(0));
    chk("rst_rd_tag", 256'(bus.rd_tag), 256'(0));
    check_state("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Round robin, then drain channel 3.
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < NCH; c++) wr(c, DW'(c * 16 + i));
    check_state("rr_fill");
    pop(3);
    chk("rr_first_x", 256'(bus.rd_x), 256'(48));
    for (int k = 1; k < 4; k++) pop(3);
    chk("rr_last_x", 256'(bus.rd_x), 256'(51));
    bus.rd_ch = CH_W'(3); #1;
    chk("rr_count3", 256'(bus.rd_count), 256'(0));
    check_state("rr_done");
    clear();

    // Overflow on channel 0.
    for (int i = 0; i < 20; i++) wr(0, DW'(i));
    check_state("ovf_fill");
    chk("ovf_flag_const", 256'(bus.ovf_flags), 256'(6'b000001));
    for (int i = 0; i < 16; i++) pop(0);
    chk("ovf_last_x", 256'(bus.rd_x), 256'(15));
    pop(0);
    check_state("ovf_drained");
    clear();

    // Decimation by 3, then decim=0 behaving as 1.
    bus.decim = DEC_W'(3);
    for (int i = 0; i < 9; i++) wr(2, DW'(i));
    check_state("dec3");
    for (int i = 0; i < 3; i++) pop(2);
    bus.decim = DEC_W'(0);
    for (int i = 0; i < 3; i++) wr(2, DW'(100 + i));
    check_state("dec0");
    for (int i = 0; i < 3; i++) pop(2);
    bus.decim = DEC_W'(1);
    clear();

    // Full channel 1 with simultaneous write and pop.
    for (int i = 0; i < 16; i++) wr(1, DW'(200 + i));
    step(1'b1, 1, DW'(999), 1'b1, 1, 1'b0);
    check_state("full_wrpop");
    for (int i = 0; i < 16; i++) pop(1);
    chk("full_last_x", 256'(bus.rd_x), 256'(999));

    // Empty channel 4 with simultaneous write and pop.
    step(1'b1, 4, DW'(44), 1'b1, 4, 1'b0);
    check_state("empty_wrpop");
    pop(4);
    clear();

    // Out-of-range channel index on write and read.
    wr(7, DW'(5));
    check_state("bad_wr");
    pop(9);
    check_state("bad_rd");

    // clr in the same cycle as a pop.
    wr(5, DW'(55));
    wr(5, DW'(56));
    step(1'b0, 0, '0, 1'b1, 5, 1'b1);
    check_state("clr_pop");

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 17; i++) wr(0, DW'(i));
    wr(8, DW'(1));
    wr(3, DW'(77));
    pop(3);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_rd_valid", 256'(bus.rd_valid), 256'(0));
    chk("mid_rst_rd_x", 256'(bus.rd_x), 256'(0));
    chk("mid_rst_rd_tag", 256'(bus.rd_tag), 256'(0));
    check_state("mid_rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pop(0);
    check_state("post_rst");
    chk("sb_empty", 256'(sb.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
